// File: rtl/cu_pkg.sv
// Shared types and defaults for the control-unit stage sequencer.
package cu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_PC_LIMIT = 512;
    localparam int          DEFAULT_TIMEOUT  = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } cuStage_e;

    typedef enum logic [2:0] {
        HC_NONE     = 3'd0,
        HC_INVALID  = 3'd1,
        HC_ALU_ERR  = 3'd2,
        HC_SYSTEM   = 3'd3,
        HC_PC_FAULT = 3'd4,
        HC_TIMEOUT  = 3'd5
    } haltCause_e;

    // A fetch address is usable only if word aligned and below the limit.
    function automatic logic pcFetchable(input logic [31:0] pc, input logic [31:0] limit);
        return (pc < limit) && (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/cu_stage_watchdog.sv
// Counts cycles spent in one handshaking state; expires on the TIMEOUT-th cycle.
module cu_stage_watchdog
    import cu_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic soc_clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] base;

    // clear marks the first cycle of a new state, so that cycle counts from zero.
    always_comb begin
        base      = clear_i ? '0 : count_q;
        count_d   = enable_i ? base + CW'(1) : '0;
        expired_o = enable_i && (base == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge soc_clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cu_stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer owning the PC and retire count.
module cu_stage_sequencer
    import cu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          PC_LIMIT = DEFAULT_PC_LIMIT,
    parameter int          TIMEOUT  = DEFAULT_TIMEOUT
) (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        poweron_i,
    output logic        fetch_req_o,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_ack_i,
    input  logic [31:0] fetch_data_i,
    output logic [31:0] ir_o,
    output logic        decode_start_o,
    input  logic        idu_ready_i,
    input  logic        needs_mem_i,
    input  logic        is_system_i,
    input  logic        invalid_instruction_i,
    output logic        alu_start_o,
    input  logic        alu_done_i,
    input  logic        alu_err_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    input  logic        mem_ack_i,
    output logic        wb_en_o,
    output logic [31:0] pc_o,
    output logic [2:0]  stage_o,
    output logic [31:0] retired_o,
    output logic        halted_o,
    output logic [2:0]  halt_cause_o
);

    localparam logic [31:0] PC_LIMIT_W = 32'(PC_LIMIT);

    cuStage_e    stage_q;
    haltCause_e  haltCause_q;
    logic        halted_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] retired_q;
    logic [31:0] nextPc_q;
    logic [31:0] nextPc_d;
    logic        needsMem_q;
    logic        fetchReq_q;
    logic        memReq_q;
    logic        decodeStart_q;
    logic        aluStart_q;
    logic        wbEn_q;
    logic        stageEntry_q;

    logic        wdEnable;
    logic        wdExpired;
    logic        faultValid;
    haltCause_e  faultCause;

    assign wdEnable = (stage_q == ST_FETCH) || (stage_q == ST_DECODE) ||
                      (stage_q == ST_EXECUTE) || (stage_q == ST_MEM);

    cu_stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .soc_clk   (soc_clk),
        .reset     (reset),
        .clear_i   (stageEntry_q),
        .enable_i  (wdEnable),
        .expired_o (wdExpired)
    );

    assign nextPc_d = branch_taken_i ? branch_target_i : pc_q + 32'd4;

    // Halt conditions per state, errors ahead of the watchdog ahead of handshakes.
    always_comb begin
        faultValid = 1'b0;
        faultCause = HC_NONE;
        case (stage_q)
            ST_FETCH: begin
                if (!pcFetchable(pc_q, PC_LIMIT_W)) begin
                    faultValid = 1'b1;
                    faultCause = HC_PC_FAULT;
                end else if (wdExpired) begin
                    faultValid = 1'b1;
                    faultCause = HC_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (invalid_instruction_i) begin
                    faultValid = 1'b1;
                    faultCause = HC_INVALID;
                end else if (wdExpired) begin
                    faultValid = 1'b1;
                    faultCause = HC_TIMEOUT;
                end else if (idu_ready_i && !stageEntry_q && is_system_i) begin
                    faultValid = 1'b1;
                    faultCause = HC_SYSTEM;
                end
            end
            ST_EXECUTE: begin
                if (alu_err_i) begin
                    faultValid = 1'b1;
                    faultCause = HC_ALU_ERR;
                end else if (wdExpired) begin
                    faultValid = 1'b1;
                    faultCause = HC_TIMEOUT;
                end
            end
            ST_MEM: begin
                if (wdExpired) begin
                    faultValid = 1'b1;
                    faultCause = HC_TIMEOUT;
                end
            end
            default: begin
                faultValid = 1'b0;
                faultCause = HC_NONE;
            end
        endcase
    end

    // Request lines are set on the edge entering their state so every output stays registered.
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            stage_q       <= ST_IDLE;
            haltCause_q   <= HC_NONE;
            halted_q      <= 1'b0;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            retired_q     <= '0;
            nextPc_q      <= RESET_PC;
            needsMem_q    <= 1'b0;
            fetchReq_q    <= 1'b0;
            memReq_q      <= 1'b0;
            decodeStart_q <= 1'b0;
            aluStart_q    <= 1'b0;
            wbEn_q        <= 1'b0;
            stageEntry_q  <= 1'b0;
        end else begin
            decodeStart_q <= 1'b0;
            aluStart_q    <= 1'b0;
            wbEn_q        <= 1'b0;
            stageEntry_q  <= 1'b0;
            if (faultValid) begin
                stage_q      <= ST_HALT;
                halted_q     <= 1'b1;
                haltCause_q  <= faultCause;
                fetchReq_q   <= 1'b0;
                memReq_q     <= 1'b0;
                stageEntry_q <= 1'b1;
            end else begin
                case (stage_q)
                    ST_IDLE: begin
                        if (poweron_i) begin
                            stage_q      <= ST_FETCH;
                            fetchReq_q   <= pcFetchable(pc_q, PC_LIMIT_W);
                            stageEntry_q <= 1'b1;
                        end
                    end
                    ST_FETCH: begin
                        if (fetchReq_q && fetch_ack_i) begin
                            ir_q          <= fetch_data_i;
                            fetchReq_q    <= 1'b0;
                            stage_q       <= ST_DECODE;
                            decodeStart_q <= 1'b1;
                            stageEntry_q  <= 1'b1;
                        end
                    end
                    ST_DECODE: begin
                        if (idu_ready_i && !stageEntry_q) begin
                            needsMem_q   <= needs_mem_i;
                            stage_q      <= ST_EXECUTE;
                            aluStart_q   <= 1'b1;
                            stageEntry_q <= 1'b1;
                        end
                    end
                    ST_EXECUTE: begin
                        if (alu_done_i && !stageEntry_q) begin
                            nextPc_q     <= nextPc_d;
                            stageEntry_q <= 1'b1;
                            if (needsMem_q) begin
                                stage_q  <= ST_MEM;
                                memReq_q <= 1'b1;
                            end else begin
                                stage_q  <= ST_WB;
                                wbEn_q   <= 1'b1;
                            end
                        end
                    end
                    ST_MEM: begin
                        if (mem_ack_i) begin
                            memReq_q     <= 1'b0;
                            stage_q      <= ST_WB;
                            wbEn_q       <= 1'b1;
                            stageEntry_q <= 1'b1;
                        end
                    end
                    ST_WB: begin
                        pc_q         <= nextPc_q;
                        retired_q    <= retired_q + 32'd1;
                        stageEntry_q <= 1'b1;
                        if (poweron_i) begin
                            stage_q    <= ST_FETCH;
                            fetchReq_q <= pcFetchable(nextPc_q, PC_LIMIT_W);
                        end else begin
                            stage_q    <= ST_IDLE;
                        end
                    end
                    ST_HALT: begin
                        stage_q <= ST_HALT;
                    end
                    default: begin
                        stage_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign fetch_req_o    = fetchReq_q;
    assign fetch_addr_o   = pc_q;
    assign ir_o           = ir_q;
    assign decode_start_o = decodeStart_q;
    assign alu_start_o    = aluStart_q;
    assign mem_req_o      = memReq_q;
    assign wb_en_o        = wbEn_q;
    assign pc_o           = pc_q;
    assign stage_o        = stage_q;
    assign retired_o      = retired_q;
    assign halted_o       = halted_q;
    assign halt_cause_o   = haltCause_q;

endmodule

// File: tb/tb_cu_stage_sequencer.sv
// Scoreboard bench: a responder answers handshakes and queues expected WB results.
module tb_cu_stage_sequencer;
    import cu_pkg::*;

    localparam int          TIMEOUT  = 64;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        soc_clk = 1'b0;
    logic        reset;
    logic        poweron;
    logic        fetch_req, fetch_ack, decode_start, idu_ready, needs_mem, is_system;
    logic        invalid_instruction, alu_start, alu_done, alu_err, branch_taken;
    logic        mem_req, mem_ack, wb_en, halted;
    logic [31:0] fetch_addr, fetch_data, ir, branch_target, pc, retired;
    logic [2:0]  stage, halt_cause;

    typedef struct {
        logic [31:0] nextPc;
        int          latency;
    } sbItem_t;

    sbItem_t     sb[$];
    int          vectorsApplied = 0;
    int          miscompares = 0;

    logic [31:0] cfgInstr, cfgTarget;
    logic        cfgNeedsMem, cfgBranch, cfgSystem, cfgInvalid, cfgAluErr, cfgFetchEnable;
    int          cfgMemDelay;

    logic [31:0] modelPc, modelRetired, expPc, expRetired;
    logic        pendingCheck;
    logic [2:0]  prevStage;
    int          cycle, fetchStart, memCount, lastMemReqLen, wbSeen;

    always #5 soc_clk = ~soc_clk;

    cu_stage_sequencer #(
        .RESET_PC (RESET_PC),
        .PC_LIMIT (512),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .soc_clk               (soc_clk),
        .reset                 (reset),
        .poweron_i             (poweron),
        .fetch_req_o           (fetch_req),
        .fetch_addr_o          (fetch_addr),
        .fetch_ack_i           (fetch_ack),
        .fetch_data_i          (fetch_data),
        .ir_o                  (ir),
        .decode_start_o        (decode_start),
        .idu_ready_i           (idu_ready),
        .needs_mem_i           (needs_mem),
        .is_system_i           (is_system),
        .invalid_instruction_i (invalid_instruction),
        .alu_start_o           (alu_start),
        .alu_done_i            (alu_done),
        .alu_err_i             (alu_err),
        .branch_taken_i        (branch_taken),
        .branch_target_i       (branch_target),
        .mem_req_o             (mem_req),
        .mem_ack_i             (mem_ack),
        .wb_en_o               (wb_en),
        .pc_o                  (pc),
        .stage_o               (stage),
        .retired_o             (retired),
        .halted_o              (halted),
        .halt_cause_o          (halt_cause)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Responder and scoreboard: one pass per negedge, monitor first, then drive.
    initial begin
        sbItem_t item;
        fetch_ack = 1'b0; fetch_data = '0; idu_ready = 1'b0; needs_mem = 1'b0;
        is_system = 1'b0; invalid_instruction = 1'b0; alu_done = 1'b0; alu_err = 1'b0;
        branch_taken = 1'b0; branch_target = '0; mem_ack = 1'b0;
        modelPc = RESET_PC; modelRetired = '0; expPc = '0; expRetired = '0;
        pendingCheck = 1'b0; prevStage = 3'd0; cycle = 0; fetchStart = 0;
        memCount = 0; lastMemReqLen = 0; wbSeen = 0;
        forever begin
            @(negedge soc_clk);
            cycle++;
            if (reset) begin
                sb.delete();
                modelPc = RESET_PC; modelRetired = '0; pendingCheck = 1'b0; memCount = 0;
                fetch_ack = 1'b0; idu_ready = 1'b0; needs_mem = 1'b0; is_system = 1'b0;
                invalid_instruction = 1'b0; alu_done = 1'b0; alu_err = 1'b0;
                branch_taken = 1'b0; mem_ack = 1'b0;
            end else begin
                if (pendingCheck) begin
                    checkOutput("wbPc", pc, expPc);
                    checkOutput("wbRetired", retired, expRetired);
                    modelPc = expPc;
                    modelRetired = expRetired;
                    pendingCheck = 1'b0;
                end
                if (stage == ST_FETCH && prevStage != ST_FETCH) fetchStart = cycle;
                if (wb_en) begin
                    wbSeen++;
                    if (sb.size() == 0) begin
                        checkOutput("wbQueueDepth", sb.size(), 1);
                    end else begin
                        item = sb.pop_front();
                        checkOutput("wbLatency", cycle - fetchStart + 1, item.latency);
                        expPc = item.nextPc;
                        expRetired = modelRetired + 32'd1;
                        pendingCheck = 1'b1;
                    end
                end
                fetch_ack = fetch_req && cfgFetchEnable;
                fetch_data = cfgInstr;
                idu_ready = (stage == ST_DECODE) && !decode_start;
                needs_mem = idu_ready && cfgNeedsMem;
                is_system = idu_ready && cfgSystem;
                invalid_instruction = idu_ready && cfgInvalid;
                alu_done = (stage == ST_EXECUTE) && !alu_start;
                alu_err = alu_done && cfgAluErr;
                branch_taken = alu_done && cfgBranch;
                branch_target = cfgTarget;
                if (alu_done && !cfgAluErr) begin
                    item.nextPc = cfgBranch ? cfgTarget : modelPc + 32'd4;
                    item.latency = 6 + (cfgNeedsMem ? 1 + cfgMemDelay : 0);
                    sb.push_back(item);
                end
                if (mem_req) begin
                    mem_ack = (memCount == cfgMemDelay);
                    memCount++;
                end else begin
                    mem_ack = 1'b0;
                    if (memCount > 0) lastMemReqLen = memCount;
                    memCount = 0;
                end
            end
            prevStage = stage;
        end
    end

    task automatic waitStage(input logic [2:0] st, input int budget, input string tag);
        int n = 0;
        while (stage !== st && n < budget) begin
            @(negedge soc_clk);
            n++;
        end
        checkOutput(tag, 32'(stage), 32'(st));
    endtask

    task automatic doReset();
        @(negedge soc_clk);
        reset = 1'b1;
        repeat (2) @(negedge soc_clk);
        reset = 1'b0;
        @(negedge soc_clk);
    endtask

    task automatic checkResetState();
        checkOutput("rstStage", 32'(stage), 32'(ST_IDLE));
        checkOutput("rstPc", pc, RESET_PC);
        checkOutput("rstIr", ir, 32'h0);
        checkOutput("rstRetired", retired, 32'h0);
        checkOutput("rstHalted", 32'(halted), 32'h0);
        checkOutput("rstCause", 32'(halt_cause), 32'h0);
        checkOutput("rstStrobes", 32'({fetch_req, mem_req, wb_en, decode_start, alu_start}), 32'h0);
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic needsMem, input int memDelay,
                                 input logic branch, input logic [31:0] target, input logic system,
                                 input logic invalid, input logic aluErr, input logic [31:0] expFetchAddr,
                                 input logic expFetchReq, input logic [2:0] expEnd);
        int n = 0;
        cfgInstr = instr; cfgNeedsMem = needsMem; cfgMemDelay = memDelay; cfgBranch = branch;
        cfgTarget = target; cfgSystem = system; cfgInvalid = invalid; cfgAluErr = aluErr;
        cfgFetchEnable = 1'b1;
        poweron = 1'b1;
        waitStage(ST_FETCH, 5, "enterFetch");
        checkOutput("fetchAddr", fetch_addr, expFetchAddr);
        checkOutput("fetchReq", 32'(fetch_req), 32'(expFetchReq));
        poweron = 1'b0;
        while (stage != ST_IDLE && stage != ST_HALT && n < 300) begin
            @(negedge soc_clk);
            n++;
        end
        checkOutput("endStage", 32'(stage), 32'(expEnd));
    endtask

    initial begin
        int n;
        reset = 1'b1; poweron = 1'b0;
        cfgInstr = '0; cfgTarget = '0; cfgNeedsMem = 1'b0; cfgBranch = 1'b0; cfgSystem = 1'b0;
        cfgInvalid = 1'b0; cfgAluErr = 1'b0; cfgFetchEnable = 1'b1; cfgMemDelay = 0;
        doReset();
        checkResetState();

        applyStimulus(32'h0050_0093, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, ST_IDLE);
        checkOutput("addiIr", ir, 32'h0050_0093);
        applyStimulus(32'h0000_a103, 1'b1, 3, 1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h4, 1'b1, ST_IDLE);
        checkOutput("loadMemReqLen", lastMemReqLen, 4);
        applyStimulus(32'h0020_a023, 1'b1, 0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h8, 1'b1, ST_IDLE);
        checkOutput("storeMemReqLen", lastMemReqLen, 1);
        applyStimulus(32'h0000_a103, 1'b1, 62, 1'b0, '0, 1'b0, 1'b0, 1'b0, 32'hC, 1'b1, ST_IDLE);
        applyStimulus(32'h0000_0463, 1'b0, 0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, ST_IDLE);
        applyStimulus(32'h0050_0093, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h40, 1'b1, ST_IDLE);
        applyStimulus(32'h0000_0463, 1'b0, 0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h44, 1'b1, ST_IDLE);
        applyStimulus(32'h0050_0093, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 32'h200, 1'b0, ST_HALT);
        checkOutput("pcFaultCause", 32'(halt_cause), 32'd4);
        checkOutput("pcFaultHalted", 32'(halted), 32'h1);
        checkOutput("pcFaultRetired", retired, 32'd7);

        doReset();
        checkResetState();
        applyStimulus(32'hFFFF_FFFF, 1'b0, 0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, ST_HALT);
        checkOutput("invalidCause", 32'(halt_cause), 32'd1);
        checkOutput("invalidRetired", retired, 32'h0);
        checkOutput("invalidNoWb", wbSeen, 7);
        doReset();
        checkOutput("postInvalidPc", pc, RESET_PC);
        checkOutput("postInvalidHalted", 32'(halted), 32'h0);

        cfgFetchEnable = 1'b0;
        poweron = 1'b1;
        waitStage(ST_FETCH, 5, "toEnterFetch");
        poweron = 1'b0;
        n = 1;
        while (n < 200) begin
            @(negedge soc_clk);
            if (stage != ST_FETCH) break;
            n++;
        end
        checkOutput("timeoutCycles", n, TIMEOUT);
        checkOutput("timeoutStage", 32'(stage), 32'(ST_HALT));
        checkOutput("timeoutCause", 32'(halt_cause), 32'd5);
        checkOutput("timeoutFetchReq", 32'(fetch_req), 32'h0);

        doReset();
        applyStimulus(32'h0000_0073, 1'b0, 0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, ST_HALT);
        checkOutput("ecallCause", 32'(halt_cause), 32'd3);
        checkOutput("ecallRetired", retired, 32'h0);

        doReset();
        applyStimulus(32'h0050_0093, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1, ST_HALT);
        checkOutput("aluErrCause", 32'(halt_cause), 32'd2);
        checkOutput("aluErrNoWb", wbSeen, 7);

        doReset();
        cfgInstr = 32'h0000_a103; cfgNeedsMem = 1'b1; cfgMemDelay = 20; cfgBranch = 1'b0;
        cfgSystem = 1'b0; cfgInvalid = 1'b0; cfgAluErr = 1'b0; cfgFetchEnable = 1'b1;
        poweron = 1'b1;
        waitStage(ST_FETCH, 5, "memRstFetch");
        poweron = 1'b0;
        waitStage(ST_MEM, 20, "memRstReachMem");
        checkOutput("memRstReqBefore", 32'(mem_req), 32'h1);
        reset = 1'b1;
        @(negedge soc_clk);
        checkOutput("memRstStage", 32'(stage), 32'(ST_IDLE));
        checkOutput("memRstReq", 32'(mem_req), 32'h0);
        @(negedge soc_clk);
        reset = 1'b0;
        repeat (3) @(negedge soc_clk);
        checkOutput("memRstRetired", retired, 32'h0);

        checkOutput("wbTotal", wbSeen, 7);
        checkOutput("sbEmpty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
